// File: rtl/vedic_divider_if.sv
// Operand/result handshake bundle for the sequential Vedic divider.
interface vedic_divider_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/vedic_divider_seq.sv
// Radix-2 restoring divider, one quotient bit per clock; inverse companion of the
// 4x4 Vedic multiplier. Valid/ready on both operand and result sides.
module vedic_divider_seq #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic            clk,
  input  logic            rst,
  vedic_divider_if.slave  bus
);

  localparam int unsigned CW = $clog2(DW + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q,     state_nxt;
  logic          in_ready_q,  in_ready_nxt;
  logic          out_valid_q, out_valid_nxt;
  logic [DW-1:0] quot_q,      quot_nxt;
  logic [VW-1:0] rem_q,       rem_nxt;
  logic          dbz_q,       dbz_nxt;
  logic [DW-1:0] dvd_q,       dvd_nxt;
  logic [VW-1:0] dvs_q,       dvs_nxt;
  logic [VW-1:0] part_q,      part_nxt;
  logic [DW-1:0] qsh_q,       qsh_nxt;
  logic [CW-1:0] cnt_q,       cnt_nxt;

  logic [VW:0]   trial;
  logic          take;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      qsh_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_nxt;
      in_ready_q  <= in_ready_nxt;
      out_valid_q <= out_valid_nxt;
      quot_q      <= quot_nxt;
      rem_q       <= rem_nxt;
      dbz_q       <= dbz_nxt;
      dvd_q       <= dvd_nxt;
      dvs_q       <= dvs_nxt;
      part_q      <= part_nxt;
      qsh_q       <= qsh_nxt;
      cnt_q       <= cnt_nxt;
    end
  end

  // Next-state and restoring-step logic; the partial remainder never exceeds VW bits
  // after a step, so only the trial carries the extra compare bit.
  always_comb begin
    state_nxt     = state_q;
    in_ready_nxt  = in_ready_q;
    out_valid_nxt = out_valid_q;
    quot_nxt      = quot_q;
    rem_nxt       = rem_q;
    dbz_nxt       = dbz_q;
    dvd_nxt       = dvd_q;
    dvs_nxt       = dvs_q;
    part_nxt      = part_q;
    qsh_nxt       = qsh_q;
    cnt_nxt       = cnt_q;
    trial         = {part_q, dvd_q[DW-1]};
    take          = (trial >= {1'b0, dvs_q});

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          dvd_nxt  = bus.dividend;
          dvs_nxt  = bus.divisor;
          part_nxt = '0;
          qsh_nxt  = '0;
          cnt_nxt  = '0;
          in_ready_nxt = 1'b0;
          if (bus.divisor == '0) begin
            state_nxt     = S_DONE;
            out_valid_nxt = 1'b1;
            quot_nxt      = '1;
            rem_nxt       = bus.dividend[VW-1:0];
            dbz_nxt       = 1'b1;
          end else begin
            state_nxt = S_RUN;
          end
        end
      end

      S_RUN: begin
        dvd_nxt = {dvd_q[DW-2:0], 1'b0};
        if (take) begin
          part_nxt = VW'(trial - {1'b0, dvs_q});
          qsh_nxt  = {qsh_q[DW-2:0], 1'b1};
        end else begin
          part_nxt = VW'(trial);
          qsh_nxt  = {qsh_q[DW-2:0], 1'b0};
        end
        cnt_nxt = cnt_q + CW'(1);
        if (cnt_q == CW'(DW - 1)) begin
          state_nxt     = S_DONE;
          out_valid_nxt = 1'b1;
          quot_nxt      = qsh_nxt;
          rem_nxt       = part_nxt;
          dbz_nxt       = 1'b0;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_nxt     = S_IDLE;
          out_valid_nxt = 1'b0;
          in_ready_nxt  = 1'b1;
        end
      end

      default: begin
        state_nxt     = S_IDLE;
        in_ready_nxt  = 1'b1;
        out_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_vedic_divider_seq.sv
// Directed self-checking bench for vedic_divider_seq.
module tb_vedic_divider_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  vedic_divider_if #(.DW(8), .VW(4)) bus ();

  vedic_divider_seq #(.DW(8), .VW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic z, output int lat);
    int w = 0;
    while (!bus.in_ready && w < 30) begin
      @(posedge clk); #1; w++;
    end
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.quotient !== 8'h00) begin errors++; $display("FAIL reset_quotient got=%h want=00", bus.quotient); end
    checks++; if (bus.remainder !== 4'h0) begin errors++; $display("FAIL reset_remainder got=%h want=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b want=0", bus.div_by_zero); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_roundtrip();
    logic [7:0] q; logic [3:0] r; logic z; int lat;
    run_op(8'd195, 4'd13, q, r, z, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL rt_latency got=%0d want=8", lat); end
    checks++; if (q !== 8'd15) begin errors++; $display("FAIL rt_quotient got=%0d want=15", q); end
    checks++; if (r !== 4'd0) begin errors++; $display("FAIL rt_remainder got=%0d want=0", r); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL rt_dbz got=%b want=0", z); end
    handoff();
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        run_op(8'(a * b), 4'(b), q, r, z, lat);
        checks++; if (q !== 8'(a)) begin errors++; $display("FAIL sweep_q %0d*%0d got=%0d want=%0d", a, b, q, a); end
        checks++; if (r !== 4'd0) begin errors++; $display("FAIL sweep_r %0d*%0d got=%0d want=0", a, b, r); end
        handoff();
      end
    end
  endtask

  task automatic test_general();
    logic [7:0] q; logic [3:0] r; logic z; int lat;
    logic [7:0] va [4] = '{8'd200, 8'd255, 8'd5, 8'd0};
    logic [3:0] vb [4] = '{4'd7, 4'd1, 4'd15, 4'd9};
    logic [7:0] eq [4] = '{8'd28, 8'd255, 8'd0, 8'd0};
    logic [3:0] er [4] = '{4'd4, 4'd0, 4'd5, 4'd0};
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], q, r, z, lat);
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL gen_q %0d/%0d got=%0d want=%0d", va[i], vb[i], q, eq[i]); end
      checks++; if (r !== er[i]) begin errors++; $display("FAIL gen_r %0d/%0d got=%0d want=%0d", va[i], vb[i], r, er[i]); end
      checks++; if (z !== 1'b0) begin errors++; $display("FAIL gen_dbz %0d/%0d got=%b want=0", va[i], vb[i], z); end
      handoff();
    end
  endtask

  task automatic test_div_by_zero();
    logic [7:0] q; logic [3:0] r; logic z; int lat;
    run_op(8'd100, 4'd0, q, r, z, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dbz_latency got=%0d want=0", lat); end
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL dbz_quotient got=%h want=ff", q); end
    checks++; if (r !== 4'd4) begin errors++; $display("FAIL dbz_remainder got=%0d want=4", r); end
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%b want=1", z); end
    handoff();
    run_op(8'd100, 4'd10, q, r, z, lat);
    checks++; if (q !== 8'd10) begin errors++; $display("FAIL after_dbz_q got=%0d want=10", q); end
    checks++; if (r !== 4'd0) begin errors++; $display("FAIL after_dbz_r got=%0d want=0", r); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL after_dbz_flag got=%b want=0", z); end
    handoff();
  endtask

  task automatic test_run_ignores_inputs();
    bus.dividend = 8'd200; bus.divisor = 4'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      bus.dividend = 8'(i * 31 + 3);
      bus.divisor  = 4'(i);
      bus.in_valid = ~bus.in_valid;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ignore_out_valid got=%b want=1", bus.out_valid); end
    checks++; if (bus.quotient !== 8'd28) begin errors++; $display("FAIL ignore_q got=%0d want=28", bus.quotient); end
    checks++; if (bus.remainder !== 4'd4) begin errors++; $display("FAIL ignore_r got=%0d want=4", bus.remainder); end
    handoff();
  endtask

  task automatic test_backpressure();
    logic [7:0] q; logic [3:0] r; logic z; int lat;
    bus.out_ready = 1'b0;
    run_op(8'd200, 4'd7, q, r, z, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", i, bus.out_valid); end
      checks++; if ({bus.quotient, bus.remainder} !== {8'd28, 4'd4}) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%0d/%0d want=28/4", i, bus.quotient, bus.remainder);
      end
    end
    handoff();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b want=0", bus.out_valid); end
    checks++; if (bus.quotient !== 8'd28) begin errors++; $display("FAIL bp_keep_q got=%0d want=28", bus.quotient); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q; logic [3:0] r; logic z; int lat;
    bus.out_ready = 1'b0;
    run_op(8'd100, 4'd10, q, r, z, lat);
    bus.dividend = 8'd50; bus.divisor = 4'd5; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_not_taken in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_out_valid got=%b want=0", bus.out_valid); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_taken in_ready got=%b want=0", bus.in_ready); end
    lat = 0;
    while (!bus.out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency got=%0d want=8", lat); end
    checks++; if (bus.quotient !== 8'd10) begin errors++; $display("FAIL b2b_q got=%0d want=10", bus.quotient); end
    handoff();
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] q; logic [3:0] r; logic z; int lat;
    int seen;
    bus.dividend = 8'd200; bus.divisor = 4'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got=%b want=0", bus.out_valid); end
    checks++; if (bus.quotient !== 8'h00) begin errors++; $display("FAIL mid_rst_q got=%h want=00", bus.quotient); end
    checks++; if (bus.remainder !== 4'h0) begin errors++; $display("FAIL mid_rst_r got=%h want=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL mid_rst_dbz got=%b want=0", bus.div_by_zero); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (bus.out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_no_result got=%0d want=0", seen); end
    // 16 does not fit a 4-bit divisor; 255/13 exercises a full run after reset instead
    run_op(8'd255, 4'd13, q, r, z, lat);
    checks++; if (q !== 8'd19) begin errors++; $display("FAIL post_rst_q got=%0d want=19", q); end
    checks++; if (r !== 4'd8) begin errors++; $display("FAIL post_rst_r got=%0d want=8", r); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL post_rst_latency got=%0d want=8", lat); end
    handoff();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_roundtrip();
    test_general();
    test_div_by_zero();
    test_run_ignores_inputs();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
